// File: rtl/mvau_weight_loader.sv
// Streams SIMD*TW-bit words from AXI-Stream into the MVAU weight memory.
// Define WLOAD_TLAST_CHECK_EN to flag tlast framing errors on load_err.
module mvau_weight_loader #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [SIMD*TW-1:0]      s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic                    wmem_we,
  output logic [WMEM_ADDR_BW-1:0] wmem_waddr,
  output logic [SIMD*TW-1:0]      wmem_wdata,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int AW = WMEM_ADDR_BW;
  localparam logic [AW-1:0] LAST = AW'(WMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cnt;
  logic          acc;
  logic          last_beat;
  logic          early;
  logic          err_set;
  logic          go;

  assign acc       = s_axis_tvalid & s_axis_tready;
  assign last_beat = (cnt == LAST);
  assign go        = (state == IDLE) & start;

`ifdef WLOAD_TLAST_CHECK_EN
  assign early   = acc & s_axis_tlast & ~last_beat;
  assign err_set = early | (acc & last_beat & ~s_axis_tlast);
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign early        = 1'b0;
  assign err_set      = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (early) begin
          state_nx = IDLE;
        end else if (acc && last_beat) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = (state == LOAD);
    busy          = (state != IDLE);
    load_done     = (state == DONE);
  end

  // Counter stops at the last address; a fresh start rewinds it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt        <= '0;
      wmem_we    <= 1'b0;
      wmem_waddr <= '0;
      wmem_wdata <= '0;
      load_err   <= 1'b0;
    end else begin
      wmem_we <= acc;
      if (acc) begin
        wmem_waddr <= cnt;
        wmem_wdata <= s_axis_tdata;
        if (!last_beat) begin
          cnt <= cnt + 1'b1;
        end
      end
      if (go) begin
        cnt      <= '0;
        load_err <= 1'b0;
      end else if (err_set) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule
